// File: rtl/demux_fluxo_param_pkg.sv
`default_nettype none
// ============================================================================
// Module   : demux_fluxo_param_pkg
// Purpose  : Shared definitions for the 1-to-N_CH stream demultiplexer:
//            routing-mode encoding, default geometry and a select-width helper.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package demux_fluxo_param_pkg;

  // Routing mode carried on auto_mode
  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_AUTO   = 1'b1
  } mode_e;

  // Default geometry used by the top level and by benches
  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_CH  = 4;
  localparam int DEF_SEL_W = 2;

  // Width of a select/pointer able to address n channels
  function automatic int sel_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/demux_fluxo_param_if.sv
`default_nettype none
// ============================================================================
// Module   : demux_fluxo_param_if
// Purpose  : Bundles the producer-side and consumer-side handshake/bus signals
//            of the stream demultiplexer.
// Ports    : in_valid/in_ready/in_data/sel/auto_mode  - producer side
//            out_valid/out_ready/out_data             - N_CH consumer channels
//            rr_ptr, sel_err                          - status
//            modport slave  : the demultiplexer
//            modport master : the environment (producer + consumers)
// Revision : 1.0  initial release
// ============================================================================
interface demux_fluxo_param_if #(
  parameter int WIDTH = 8,
  parameter int N_CH  = 4,
  parameter int SEL_W = 2
);

  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        in_data;
  logic [SEL_W-1:0]        sel;
  logic                    auto_mode;
  logic [N_CH-1:0]         out_valid;
  logic [N_CH-1:0]         out_ready;
  logic [N_CH*WIDTH-1:0]   out_data;
  logic [SEL_W-1:0]        rr_ptr;
  logic                    sel_err;

  modport slave (
    input  in_valid, in_data, sel, auto_mode, out_ready,
    output in_ready, out_valid, out_data, rr_ptr, sel_err
  );

  modport master (
    output in_valid, in_data, sel, auto_mode, out_ready,
    input  in_ready, out_valid, out_data, rr_ptr, sel_err
  );

endinterface
`default_nettype wire

// File: rtl/demux_fluxo_param_canal_reg.sv
`default_nettype none
// ============================================================================
// Module   : demux_fluxo_param_canal_reg
// Purpose  : One-entry valid/data holding register for a single output
//            channel. A load and a drain on the same edge replace the word
//            and keep the entry valid, giving full throughput.
// Ports    : clk, rst_n       - clock, asynchronous active-low reset
//            i_load, i_data   - write a new word at the next edge
//            i_ready          - consumer accepts the held word
//            o_valid, o_data  - held word
// Revision : 1.0  initial release
// ============================================================================
module demux_fluxo_param_canal_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             valid_d, valid_q;
  logic [WIDTH-1:0] data_d,  data_q;

  always_comb begin
    // A reload wins over a drain; otherwise the word leaves when accepted.
    valid_d = i_load | (valid_q & ~i_ready);
    // Data only moves on a load, so it is stable while stalled.
    data_d  = i_load ? i_data : data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule
`default_nettype wire

// File: rtl/demux_fluxo_param.sv
`default_nettype none
// ============================================================================
// Module   : demux_fluxo_param
// Purpose  : Registered 1-to-N_CH stream demultiplexer with valid/ready on the
//            input and on every output. Target channel is either chosen by
//            sel (manual) or by an internal round-robin pointer (auto).
//            Each channel owns a one-entry holding register, so latency is
//            one cycle and backpressure is per channel.
// Ports    : clk    - rising-edge clock
//            rst_n  - asynchronous active-low reset
//            bus    - demux_fluxo_param_if.slave (handshakes, data, status)
// Revision : 1.0  initial release
// ============================================================================
module demux_fluxo_param
  import demux_fluxo_param_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int N_CH  = DEF_N_CH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  demux_fluxo_param_if.slave   bus
);

  // SEL_W must be exactly wide enough to address every channel.
  if (SEL_W != sel_width(N_CH)) begin : g_param_chk
    $error("demux_fluxo_param: SEL_W does not match N_CH");
  end

  localparam logic [SEL_W-1:0] C_LAST_CH = SEL_W'(N_CH - 1);

  logic [SEL_W-1:0] w_tgt;
  logic [N_CH-1:0]  w_hit;
  logic [N_CH-1:0]  w_free;
  logic [N_CH-1:0]  w_load;
  logic             w_in_range;
  logic             w_in_ready;
  logic             w_accept;
  logic             w_auto;

  logic [SEL_W-1:0] rr_ptr_d, rr_ptr_q;
  logic             sel_err_d, sel_err_q;

  logic             w_ch_valid [N_CH];
  logic [WIDTH-1:0] w_ch_data  [N_CH];
  logic [N_CH-1:0]       w_out_valid;
  logic [N_CH*WIDTH-1:0] w_out_data;

  // --------------------------------------------------------------------------
  // Target decode and input handshake
  // --------------------------------------------------------------------------
  always_comb begin
    w_auto = (bus.auto_mode == MODE_AUTO);
    w_tgt  = w_auto ? rr_ptr_q : bus.sel;
    w_hit  = '0;
    w_free = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_hit[k]  = (w_tgt == SEL_W'(k));
      // Free when empty or being emptied at this same edge.
      w_free[k] = ~w_ch_valid[k] | bus.out_ready[k];
    end
    // No channel matches only for a manual sel >= N_CH; rr_ptr never leaves range.
    w_in_range = |w_hit;
    // Out-of-range words are swallowed so the producer is never wedged.
    w_in_ready = ~w_in_range | (|(w_hit & w_free));
    w_accept   = bus.in_valid & w_in_ready;
    w_load     = {N_CH{w_accept}} & w_hit;
    sel_err_d  = bus.in_valid & ~w_auto & ~w_in_range;
  end

  // --------------------------------------------------------------------------
  // Round-robin pointer: moves only on accepted auto-mode transfers and is
  // left alone by mode changes.
  // --------------------------------------------------------------------------
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_auto && w_accept) begin
      rr_ptr_d = (rr_ptr_q == C_LAST_CH) ? '0 : rr_ptr_q + SEL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      sel_err_q <= sel_err_d;
    end
  end

  // --------------------------------------------------------------------------
  // Per-channel holding registers
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    demux_fluxo_param_canal_reg #(
      .WIDTH (WIDTH)
    ) u_canal (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[k]),
      .i_data  (bus.in_data),
      .i_ready (bus.out_ready[k]),
      .o_valid (w_ch_valid[k]),
      .o_data  (w_ch_data[k])
    );
  end

  // Pack channel outputs; channel k occupies bits [k*WIDTH +: WIDTH].
  always_comb begin
    w_out_valid = '0;
    w_out_data  = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_out_valid[k]               = w_ch_valid[k];
      w_out_data[k*WIDTH +: WIDTH] = w_ch_data[k];
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_out_data;
  assign bus.rr_ptr    = rr_ptr_q;
  assign bus.sel_err   = sel_err_q;

endmodule
`default_nettype wire

// File: tb/tb_demux_fluxo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_fluxo_param
// Purpose  : Self-checking bench for demux_fluxo_param. A 4-channel instance
//            is followed by a reference model whose per-channel queues take
//            a word when the producer handshake completes and release it when
//            the consumer takes it; a 3-channel instance exercises the
//            out-of-range select path.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_demux_fluxo_param;

  localparam int WIDTH = 8;
  localparam int N_A   = 4;
  localparam int N_B   = 3;

  logic clk;
  logic rst_n;

  demux_fluxo_param_if #(.WIDTH(WIDTH), .N_CH(N_A), .SEL_W(2)) bus_a ();
  demux_fluxo_param_if #(.WIDTH(WIDTH), .N_CH(N_B), .SEL_W(2)) bus_b ();

  demux_fluxo_param #(.WIDTH(WIDTH), .N_CH(N_A), .SEL_W(2)) u_dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a)
  );

  demux_fluxo_param #(.WIDTH(WIDTH), .N_CH(N_B), .SEL_W(2)) u_dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model for the 4-channel instance, sampled 1 time unit before
  // each rising edge.
  // --------------------------------------------------------------------------
  logic [7:0] exp_q [N_A][$];
  int         mdl_ptr;
  logic       mdl_err;
  logic [3:0] exp_v;
  int         tgt;
  logic       exp_rdy;

  initial begin
    mdl_ptr = 0;
    mdl_err = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst_n) begin
        for (int k = 0; k < N_A; k++) exp_q[k].delete();
        mdl_ptr = 0;
        mdl_err = 1'b0;
      end else begin
        for (int k = 0; k < N_A; k++) exp_v[k] = (exp_q[k].size() != 0);
        check_eq("out_valid", 32'(bus_a.out_valid), 32'(exp_v));
        check_eq("rr_ptr",    32'(bus_a.rr_ptr),    32'(mdl_ptr));
        check_eq("sel_err",   32'(bus_a.sel_err),   32'(mdl_err));

        tgt = bus_a.auto_mode ? mdl_ptr : int'(bus_a.sel);
        if (tgt >= N_A) exp_rdy = 1'b1;
        else            exp_rdy = (exp_q[tgt].size() == 0) || bus_a.out_ready[tgt];
        check_eq("in_ready", 32'(bus_a.in_ready), 32'(exp_rdy));

        for (int k = 0; k < N_A; k++) begin
          if (exp_q[k].size() != 0) begin
            check_eq($sformatf("out_data%0d", k), 32'(bus_a.out_data[k*WIDTH +: WIDTH]),
                     32'(exp_q[k][0]));
            if (bus_a.out_ready[k]) void'(exp_q[k].pop_front());
          end
        end

        mdl_err = bus_a.in_valid && !bus_a.auto_mode && (tgt >= N_A);
        if (bus_a.in_valid && exp_rdy && (tgt < N_A)) begin
          exp_q[tgt].push_back(bus_a.in_data);
          if (bus_a.auto_mode) mdl_ptr = (mdl_ptr == N_A - 1) ? 0 : mdl_ptr + 1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers (entered and left on a falling edge)
  // --------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [7:0] d, input logic [1:0] s);
    bus_a.in_valid = 1'b1;
    bus_a.in_data  = d;
    bus_a.sel      = s;
  endtask

  task automatic wait_accept();
    int   budget;
    logic acc;
    budget = 20;
    acc    = 1'b0;
    while (!acc && budget > 0) begin
      #4;
      acc = bus_a.in_ready;
      @(negedge clk);
      budget--;
    end
    if (!acc) check_eq("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send(input logic [7:0] d, input logic [1:0] s);
    drive(d, s);
    wait_accept();
  endtask

  task automatic idle();
    bus_a.in_valid = 1'b0;
  endtask

  // --------------------------------------------------------------------------
  // Main sequence
  // --------------------------------------------------------------------------
  initial begin
    rst_n           = 1'b0;
    bus_a.in_valid  = 1'b0;
    bus_a.in_data   = '0;
    bus_a.sel       = '0;
    bus_a.auto_mode = 1'b0;
    bus_a.out_ready = 4'hF;
    bus_b.in_valid  = 1'b0;
    bus_b.in_data   = '0;
    bus_b.sel       = '0;
    bus_b.auto_mode = 1'b0;
    bus_b.out_ready = 3'b111;

    step(3);
    rst_n = 1'b1;
    #4;
    check_eq("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check_eq("rst_out_data",  32'(bus_a.out_data),  32'd0);
    @(negedge clk);

    // Manual sweep, back-to-back
    for (int k = 0; k < N_A; k++) send(8'hA0 + 8'(k), 2'(k));
    idle();
    step(2);

    // Backpressure on channel 2
    bus_a.out_ready = 4'b1011;
    send(8'h11, 2'd2);
    drive(8'h22, 2'd2);
    for (int i = 0; i < 2; i++) begin
      #4;
      check_eq("bp_in_ready", 32'(bus_a.in_ready), 32'd0);
      check_eq("bp_hold",     32'(bus_a.out_data[23:16]), 32'h11);
      @(negedge clk);
    end
    bus_a.out_ready = 4'hF;
    wait_accept();
    idle();
    #4;
    check_eq("bp_reload_valid", 32'(bus_a.out_valid[2]), 32'd1);
    check_eq("bp_reload_data",  32'(bus_a.out_data[23:16]), 32'h22);
    @(negedge clk);
    step(2);

    // Auto mode wrap
    bus_a.auto_mode = 1'b1;
    for (int i = 1; i <= 6; i++) send(8'(i), 2'($urandom_range(0, 3)));
    idle();
    #4;
    check_eq("auto_ptr_end", 32'(bus_a.rr_ptr), 32'd2);
    @(negedge clk);
    bus_a.auto_mode = 1'b0;
    step(3);
    bus_a.auto_mode = 1'b1;
    #4;
    check_eq("auto_ptr_toggle", 32'(bus_a.rr_ptr), 32'd2);
    @(negedge clk);

    // Auto stall: channel 1 full and blocked while the pointer sits on it
    bus_a.out_ready = 4'b1101;
    for (int i = 0; i < 7; i++) send(8'h30 + 8'(i), 2'd0);
    drive(8'h40, 2'd0);
    for (int i = 0; i < 3; i++) begin
      #4;
      check_eq("stall_in_ready", 32'(bus_a.in_ready), 32'd0);
      check_eq("stall_ptr",      32'(bus_a.rr_ptr),   32'd1);
      @(negedge clk);
    end
    bus_a.out_ready = 4'hF;
    wait_accept();
    idle();
    step(3);

    // Out-of-range select on the 3-channel instance
    bus_b.out_ready = 3'b111;
    bus_b.sel       = 2'd3;
    bus_b.in_data   = 8'h5A;
    bus_b.in_valid  = 1'b1;
    #4;
    check_eq("b_in_ready_oor", 32'(bus_b.in_ready), 32'd1);
    check_eq("b_sel_err_pre",  32'(bus_b.sel_err),  32'd0);
    check_eq("b_out_data_init", 32'(bus_b.out_data), 32'd0);
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    #4;
    check_eq("b_sel_err_pulse", 32'(bus_b.sel_err),   32'd1);
    check_eq("b_out_valid_oor", 32'(bus_b.out_valid), 32'd0);
    @(negedge clk);
    #4;
    check_eq("b_sel_err_clear", 32'(bus_b.sel_err), 32'd0);
    @(negedge clk);
    bus_b.sel      = 2'd2;
    bus_b.in_data  = 8'h3C;
    bus_b.in_valid = 1'b1;
    #4;
    check_eq("b_in_ready_ok", 32'(bus_b.in_ready), 32'd1);
    @(negedge clk);
    bus_b.in_valid = 1'b0;
    #4;
    check_eq("b_out_valid_ok", 32'(bus_b.out_valid), 32'b100);
    check_eq("b_out_data_ok",  32'(bus_b.out_data),  32'h3C0000);
    check_eq("b_sel_err_none", 32'(bus_b.sel_err),   32'd0);
    @(negedge clk);

    // Asynchronous reset with channels 0 and 2 occupied
    bus_a.auto_mode = 1'b0;
    bus_a.out_ready = 4'h0;
    send(8'h55, 2'd0);
    send(8'hAA, 2'd2);
    idle();
    #4;
    check_eq("pre_rst_valid", 32'(bus_a.out_valid), 32'b0101);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check_eq("arst_out_data",  32'(bus_a.out_data),  32'd0);
    check_eq("arst_rr_ptr",    32'(bus_a.rr_ptr),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_a.out_ready = 4'hF;
    step(2);
    #4;
    check_eq("post_rst_data", 32'(bus_a.out_data), 32'd0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
